// File: rtl/lsu_pkg.sv
// LSU shared definitions: RISC-V widths, access-size and FSM encodings, byte-mask constants.
// The optional LSU_MISALIGNED_EN macro is consumed by lsu.sv.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package lsu_pkg;

    localparam int unsigned WordWidth = `RISCV_WORD_WIDTH;

    // Access size as carried on req_size_i
    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue0 = 3'd1,
        StWait0  = 3'd2,
        StIssue1 = 3'd3,
        StWait1  = 3'd4,
        StDone   = 3'd5
    } state_e;

    localparam logic [3:0] MaskByte = 4'b0001;
    localparam logic [3:0] MaskHalf = 4'b0011;
    localparam logic [3:0] MaskWord = 4'b1111;

    // Unshifted byte-enable mask for an access size; illegal size enables nothing
    function automatic logic [3:0] size_mask(input size_e size);
        case (size)
            SizeByte: return MaskByte;
            SizeHalf: return MaskHalf;
            SizeWord: return MaskWord;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready RAM port between the LSU (master, initiator) and the memory (slave).

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

interface lsu_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH
) ();

    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WordWidth-1:0]  mem_wdata_o;
    logic [3:0]            mem_we_o;
    logic [WordWidth-1:0]  mem_rdata_i;

    modport master (
        output mem_valid_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_we_o,
        input  mem_ready_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_valid_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_we_o,
        output mem_ready_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational data aligner: byte enables and shifted store data spanning two words,
// and byte selection plus zero/sign extension of a two-word load window.

module lsu_align
    import lsu_pkg::*;
(
    input  size_e                  i_size,
    input  logic                   i_signed,
    input  logic [1:0]             i_offset,
    input  logic [WordWidth-1:0]   i_wdata,
    input  logic [2*WordWidth-1:0] i_rdata,   // {next word, low word}
    output logic [7:0]             o_be,      // [3:0] first beat, [7:4] second beat
    output logic [2*WordWidth-1:0] o_wdata,
    output logic [WordWidth-1:0]   o_rdata
);

    logic [4:0]           w_bit_shift;
    logic [WordWidth-1:0] w_rdata_lo;

    assign w_bit_shift = {i_offset, 3'b000};
    assign o_be        = {4'b0000, size_mask(i_size)} << i_offset;
    assign o_wdata     = {{WordWidth{1'b0}}, i_wdata} << w_bit_shift;
    assign w_rdata_lo  = WordWidth'(i_rdata >> w_bit_shift);

    // Extend the selected load bytes from bit 7 or bit 15; words pass straight through
    always_comb begin
        o_rdata = w_rdata_lo;
        unique case (i_size)
            SizeByte: o_rdata = {{(WordWidth-8){i_signed & w_rdata_lo[7]}}, w_rdata_lo[7:0]};
            SizeHalf: o_rdata = {{(WordWidth-16){i_signed & w_rdata_lo[15]}}, w_rdata_lo[15:0]};
            default:  ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, issued as one or two word beats on the RAM port.
// Define LSU_MISALIGNED_EN to split word-crossing misaligned accesses into two beats;
// without it, misaligned accesses complete immediately with resp_err_o = 1.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WordWidth-1:0]  req_wdata_i,
    output logic                  resp_valid_o,
    output logic [WordWidth-1:0]  resp_rdata_o,
    output logic                  resp_err_o,
    lsu_if.master                 mem
);

    state_e                  r_state;
    logic                    r_we;
    size_e                   r_size;
    logic                    r_signed;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WordWidth-1:0]    r_wdata;
    logic                    r_split;
    logic [WordWidth-1:0]    r_beat0;
    logic                    r_mem_valid;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [WordWidth-1:0]    r_mem_wdata;
    logic [3:0]              r_mem_we;
    logic                    r_resp_valid;
    logic [WordWidth-1:0]    r_resp_rdata;
    logic                    r_resp_err;

    logic                    w_idle;
    size_e                   w_size;
    logic                    w_signed;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [WordWidth-1:0]    w_wdata;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic                    w_split;
    logic [2*WordWidth-1:0]  w_rdata_merged;
    logic [7:0]              w_be;
    logic [2*WordWidth-1:0]  w_st_data;
    logic [WordWidth-1:0]    w_ld_data;

    // In IDLE the aligner sees the live request so the first beat can register on acceptance
    assign w_idle      = (r_state == StIdle);
    assign w_size      = w_idle ? size_e'(req_size_i) : r_size;
    assign w_signed    = w_idle ? req_signed_i : r_signed;
    assign w_addr      = w_idle ? req_addr_i : r_addr;
    assign w_wdata     = w_idle ? req_wdata_i : r_wdata;
    assign w_word_addr = {w_addr[ADDR_WIDTH-1:2], 2'b00};

    assign w_misaligned = ((w_size == SizeHalf) && w_addr[0]) ||
                          ((w_size == SizeWord) && (w_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGNED_EN
    assign w_illegal = (w_size == SizeIllegal);
    assign w_split   = w_misaligned && (w_be[7:4] != 4'b0000);
`else
    assign w_illegal = (w_size == SizeIllegal) || w_misaligned;
    assign w_split   = 1'b0;
`endif

    // Second beat supplies the upper word of the load window
    assign w_rdata_merged = (r_state == StWait1) ? {mem.mem_rdata_i, r_beat0}
                                                 : {{WordWidth{1'b0}}, mem.mem_rdata_i};

    lsu_align u_align (
        .i_size   (w_size),
        .i_signed (w_signed),
        .i_offset (w_addr[1:0]),
        .i_wdata  (w_wdata),
        .i_rdata  (w_rdata_merged),
        .o_be     (w_be),
        .o_wdata  (w_st_data),
        .o_rdata  (w_ld_data)
    );

    assign req_ready_o     = w_idle;
    assign resp_valid_o    = r_resp_valid;
    assign resp_rdata_o    = r_resp_rdata;
    assign resp_err_o      = r_resp_err;
    assign mem.mem_valid_o = r_mem_valid;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_wdata_o = r_mem_wdata;
    assign mem.mem_we_o    = r_mem_we;

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_size       <= SizeByte;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_split      <= 1'b0;
            r_beat0      <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_we     <= req_we_i;
                        r_size   <= w_size;
                        r_signed <= req_signed_i;
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_split  <= w_split;
                        if (w_illegal) begin
                            r_state      <= StDone;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= StIssue0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_we    <= req_we_i ? w_be[3:0] : 4'b0000;
                            r_mem_wdata <= w_st_data[WordWidth-1:0];
                        end
                    end
                end
                StIssue0: r_state <= StWait0;
                StIssue1: r_state <= StWait1;
                StWait0, StWait1: begin
                    if (mem.mem_ready_i) begin
                        r_beat0 <= mem.mem_rdata_i;
                        if ((r_state == StWait0) && r_split) begin
                            r_state     <= StIssue1;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(4);
                            r_mem_we    <= r_we ? w_be[7:4] : 4'b0000;
                            r_mem_wdata <= w_st_data[2*WordWidth-1:WordWidth];
                        end else begin
                            r_state      <= StDone;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= r_we ? '0 : w_ld_data;
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default `RISCV_ADDR_WIDTH, bus and request address width.
REQ-002 Port clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port req_valid_i  input  1  core request present.
REQ-005 Port req_ready_o  output  1  LSU idle and accepting a request.
REQ-006 Port req_we_i  input  1  1 = store, 0 = load.
REQ-007 Port req_size_i  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 Port req_signed_i  input  1  sign-extend the load result.
REQ-009 Port req_addr_i  input  ADDR_WIDTH  byte address.
REQ-010 Port req_wdata_i  input  `RISCV_WORD_WIDTH  store data, right-aligned.
REQ-011 Port resp_valid_o  output  1  one-cycle completion pulse.
REQ-012 Port resp_rdata_o  output  `RISCV_WORD_WIDTH  extended load data, valid with resp_valid_o.
REQ-013 Port resp_err_o  output  1  illegal size or misaligned-trap error, valid with resp_valid_o.
REQ-014 Ports mem_valid_o (out, 1), mem_ready_i (in, 1), mem_addr_o (out, ADDR_WIDTH), mem_wdata_o (out, `RISCV_WORD_WIDTH), mem_we_o (out, 4), mem_rdata_i (in, `RISCV_WORD_WIDTH) form the initiator side of the team's valid/ready RAM port.

Function
REQ-015 FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE; req_ready_o = 1 only in IDLE.
REQ-016 IDLE: when req_valid_i is high, latch all req_* fields. Go to DONE with an error if the request is illegal; otherwise go to ISSUE0.
REQ-017 ISSUE0/ISSUE1: mem_valid_o is high for exactly one cycle, then the FSM moves to WAIT0/WAIT1; mem_valid_o is low in every other state.
REQ-018 WAIT0/WAIT1: mem_valid_o stays low and the FSM holds until mem_ready_i is high. On that cycle it captures mem_rdata_i and goes to ISSUE1 (second beat needed) or DONE.
REQ-019 mem_ready_i is ignored in IDLE, ISSUE0, ISSUE1 and DONE.
REQ-020 mem_addr_o is the word-aligned address ({addr[ADDR_WIDTH-1:2], 2'b00}; second beat: that value + 4, wrapping modulo 2^ADDR_WIDTH).
REQ-021 Store: mem_we_o = size mask (0001/0011/1111) << addr[1:0], truncated per beat; mem_wdata_o = wdata << 8*addr[1:0]. Load: mem_we_o = 0000.
REQ-022 Load result: bytes are selected from offset addr[1:0], then zero- or sign-extended per req_signed_i from bit 7 (byte) or bit 15 (half); a word is passed through.
REQ-023 DONE: resp_valid_o is high for one cycle, then the FSM returns to IDLE. Aligned-access latency: accept at T, mem_valid_o at T+1, mem_ready_i earliest at T+2, resp_valid_o at T+3.
REQ-024 resp_rdata_o and resp_err_o hold their values until the next DONE; for a store, resp_rdata_o = 0.
REQ-025 An access is misaligned when it is a half with addr[0]=1 or a word with addr[1:0]!=0.

Reset
REQ-026 Reset: state = IDLE; mem_valid_o, resp_valid_o, resp_err_o and mem_we_o = 0; resp_rdata_o, mem_addr_o and mem_wdata_o = 0.
REQ-027 Reset mid-transaction abandons it: no resp_valid_o is issued, and a later mem_ready_i is ignored per REQ-019.

Configuration
REQ-028 Macro LSU_MISALIGNED_EN defined: a misaligned access that crosses a word boundary is split into two beats (low word, then next word). Load bytes are merged across both beats; store byte enables are split across both beats; resp_err_o = 0.
REQ-029 LSU_MISALIGNED_EN undefined: a misaligned access issues no bus beat and goes IDLE->DONE with resp_err_o = 1; ISSUE1/WAIT1 are unreachable.
REQ-030 A misaligned half at addr[1:0]=01 stays within one word and is always a single beat.

Structure
REQ-031 The shared package/defines file holds the size encodings, the FSM state encodings and the 4-bit byte-mask constants, next to the RISCV_ defines.
REQ-032 One sub-module, lsu_align, is combinational: it maps (size, signed, offset, data) to byte enables, shifted store data and extended load data.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10 -> one beat, mem_addr_o=0x10, mem_we_o=1111, resp_valid_o 3 cycles after acceptance with err=0.
REQ-034 RAM word 0x80FF7F01 at 0x20; signed byte load at 0x23 -> 0xFFFFFF80; unsigned half load at 0x22 -> 0x000080FF.
REQ-035 Store byte 0xAB at 0x31 -> mem_we_o=0010, mem_wdata_o[15:8]=0xAB.
REQ-036 Word load at 0x42 with 0x11223344 at 0x40 and 0x55667788 at 0x44. With LSU_MISALIGNED_EN: beats to 0x40 then 0x44, result 0x77881122, err=0. Without it: no mem_valid_o, err=1.
REQ-037 Drive rst high in WAIT0, then drive mem_ready_i -> no resp_valid_o, req_ready_o=1, mem_valid_o=0.
REQ-038 Delay mem_ready_i by 5 cycles -> mem_valid_o stays low in WAIT0 and resp_valid_o pulses exactly once.
